alu_arbiter: RTL

Shares one combinational `alu` instance between NREQ requesters (e.g. the execute stage and the branch/address unit) in the reduced RISC-V core. Accepts one operation per cycle through per-requester valid/ready handshakes, using round-robin priority. Drives the ALU operand and control inputs, and registers `aluout`/`eq` into a single response slot. Returns each result to its originator with a one-cycle latency.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_arbiter_rr_picker.sv | 36 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU arbiter and its users.
//   - ALU opcode constants (3-bit aluctrl encoding of the shared ALU)
//   - arb_state_t: response-slot state of the arbiter
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
// Finds the first set bit of valid at or after ptr, wrapping modulo NREQ.
// Ports:
//   valid  in  NREQ   candidate requests
//   ptr    in  IW     search start position
//   grant  out NREQ   one-hot grant (zero when nothing is valid)
//   idx    out IW     index of the granted requester (0 when none)
//   any    out 1      some requester was found
module rr_picker #(
   parameter int NREQ = 2,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between NREQ requesters.
// One op is accepted per cycle (round-robin); its ALU result is registered
// into a single response slot and returned to its originator one cycle later.
//
// Optional feature macro: ALU_ARB_LOCK_EN
//   When defined, a handshake with req_lock[g]=1 locks the grant to g until
//   g hands over an op with req_lock[g]=0 (atomic multi-op sequences).
//   When undefined, the req_lock port does not exist.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready [NREQ]        request handshake per requester
//   req_alusrc, req_aluctrl,
//   req_op1, req_imm, req_reg         per-requester ALU fields
//   req_lock [NREQ]                   (ALU_ARB_LOCK_EN only) keep grant
//   alu_alusrc .. alu_reg             muxed fields to the shared ALU
//   alu_out, alu_eq                   ALU result inputs
//   rsp_valid/rsp_ready [NREQ]        response handshake per requester
//   rsp_data, rsp_eq                  registered result
//   dbg_state, dbg_rr_ptr             slot state and round-robin pointer
//
// Handshake rule: a transfer happens on a cycle where valid and ready are both
// 1 at the rising clock edge. req_ready never waits on the requester's own
// valid beyond arbitration; rsp_valid stays asserted until the owner's
// rsp_ready is 1.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int NREQ    = 2,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ-1:0]               req_alusrc,
   input  logic [NREQ-1:0][2:0]          req_aluctrl,
   input  logic [NREQ-1:0][D_WIDTH-1:0]  req_op1,
   input  logic [NREQ-1:0][D_WIDTH-1:0]  req_imm,
   input  logic [NREQ-1:0][D_WIDTH-1:0]  req_reg,
`ifdef ALU_ARB_LOCK_EN
   input  logic [NREQ-1:0]               req_lock,
`endif
   output logic                          alu_alusrc,
   output logic [2:0]                    alu_aluctrl,
   output logic [D_WIDTH-1:0]            alu_op1,
   output logic [D_WIDTH-1:0]            alu_imm,
   output logic [D_WIDTH-1:0]            alu_reg,
   input  logic [D_WIDTH-1:0]            alu_out,
   input  logic                          alu_eq,
   output logic [NREQ-1:0]               rsp_valid,
   input  logic [NREQ-1:0]               rsp_ready,
   output logic [D_WIDTH-1:0]            rsp_data,
   output logic                          rsp_eq,
   output arb_state_t                    dbg_state,
   output logic [IW-1:0]                 dbg_rr_ptr
);

   arb_state_t      state_q, state_d;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   rsp_id_q;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   ptr_next;
   logic            any;
   logic            drain;
   logic            free_next;
   logic            hs;

   // The owner's rsp_ready frees the slot in the same cycle, so a new op can
   // be accepted while the old result is being taken (full throughput).
   assign drain     = (state_q == FULL) && rsp_ready[rsp_id_q];
   assign free_next = (state_q == EMPTY) || drain;

`ifdef ALU_ARB_LOCK_EN
   logic            lock_q;
   logic [IW-1:0]   lock_id_q;
   assign eligible = lock_q ? (req_valid & (NREQ'(1) << lock_id_q)) : req_valid;
`else
   assign eligible = req_valid;
`endif

   rr_picker #(.NREQ(NREQ)) u_picker (
      .valid (eligible),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .idx   (gidx),
      .any   (any)
   );

   assign req_ready = (!rst && free_next) ? grant : '0;
   assign hs        = |(req_valid & req_ready);
   assign ptr_next  = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);

   // Requester 0 drives the ALU when nobody is selected, keeping it stable.
   assign sel         = any ? gidx : '0;
   assign alu_alusrc  = req_alusrc[sel];
   assign alu_aluctrl = req_aluctrl[sel];
   assign alu_op1     = req_op1[sel];
   assign alu_imm     = req_imm[sel];
   assign alu_reg     = req_reg[sel];

   always_comb begin
      state_d = state_q;
      if (hs) begin
         state_d = FULL;
      end else if (drain) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         rr_ptr_q <= '0;
         rsp_id_q <= '0;
         rsp_data <= '0;
         rsp_eq   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
         lock_q    <= 1'b0;
         lock_id_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (hs) begin
            rsp_data <= alu_out;
            rsp_eq   <= alu_eq;
            rsp_id_q <= gidx;
`ifdef ALU_ARB_LOCK_EN
            // While locked only the lock holder is granted; the pointer
            // freezes and the holder decides whether to keep the lock.
            if (lock_q) begin
               lock_q <= req_lock[gidx];
            end else begin
               rr_ptr_q  <= ptr_next;
               lock_q    <= req_lock[gidx];
               lock_id_q <= gidx;
            end
`else
            rr_ptr_q <= ptr_next;
`endif
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = (state_q == FULL) && (rsp_id_q == IW'(i));
      end
   end

   assign dbg_state  = state_q;
   assign dbg_rr_ptr = rr_ptr_q;

endmodule
